vga_timing_gen: RTL and testbench

Parametrised VGA raster timing generator: generation successor to the fixed 640x480 controller with its external divide-by-2 toggle. Integrates the pixel clock-enable divider and makes every porch/sync/active length, sync polarity and divide ratio a parameter. Adds a runtime enable, per-line/per-frame strobes and a frame counter. Sits between the top-level clock/reset and the pixel colour generator, which consumes `row`, `column`, `display_active` and `pix_en`.

---
 rtl/vga_pkg.sv | 45 ++++
 rtl/pixel_clk_en.sv | 50 +++++
 rtl/vga_timing_gen_chk.sv | 29 ++
 rtl/vga_timing_gen.sv | 180 ++++++++++++++++++
 tb/tb_vga_timing_gen.sv | 315 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vga_pkg.sv
// vga_pkg: shared constants and helpers for the VGA raster timing generator.
// Holds the 640x480@60 default lengths, a struct bundling the eight
// porch/sync/active lengths, and a function that sums one axis of it.
package vga_pkg;

  // 640x480@60 with a 50 MHz clk and a divide-by-2 pixel strobe
  localparam int DEF_CLK_DIV  = 2;
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;
  localparam int DEF_FRAME_W  = 8;

  typedef struct packed {
    logic [15:0] h_active;
    logic [15:0] h_fp;
    logic [15:0] h_sync;
    logic [15:0] h_bp;
    logic [15:0] v_active;
    logic [15:0] v_fp;
    logic [15:0] v_sync;
    logic [15:0] v_bp;
  } vga_timing_t;

  typedef enum logic [0:0] {
    AXIS_H = 1'b0,
    AXIS_V = 1'b1
  } vga_axis_e;

  // Total line length (AXIS_H, in pixels) or frame length (AXIS_V, in lines)
  function automatic int unsigned timing_total(input vga_timing_t t, input vga_axis_e axis);
    int unsigned len_s;
    case (axis)
      AXIS_H:  len_s = 32'(t.h_active) + 32'(t.h_fp) + 32'(t.h_sync) + 32'(t.h_bp);
      AXIS_V:  len_s = 32'(t.v_active) + 32'(t.v_fp) + 32'(t.v_sync) + 32'(t.v_bp);
      default: len_s = 32'd0;
    endcase
    return len_s;
  endfunction

endpackage

// File: rtl/pixel_clk_en.sv
// pixel_clk_en: divides clk down to a one-clk pixel strobe.
// Ports:
//   clk    in  system clock
//   rst    in  asynchronous active-high reset
//   en     in  run enable; low parks the divider at 0
//   pix_en out high for one clk every CLK_DIV clks while running
module pixel_clk_en #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic pix_en
);

  localparam int            DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] div_cnt_r;
  logic [DW-1:0] div_nxt_s;
  logic          div_last_s;

  // Divider next value: counts 0..CLK_DIV-1, parked at 0 while disabled
  always_comb begin
    div_last_s = (div_cnt_r == DIV_LAST);
    div_nxt_s  = {DW{1'b0}};
    if (!en) begin
      div_nxt_s = {DW{1'b0}};
    end else if (div_last_s) begin
      div_nxt_s = {DW{1'b0}};
    end else begin
      div_nxt_s = div_cnt_r + DW'(1);
    end
  end

  // Divider state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt_r <= {DW{1'b0}};
    end else begin
      div_cnt_r <= div_nxt_s;
    end
  end

  // The strobe is a decode of the divider register. It is gated by en and rst
  // so that with CLK_DIV=1 the very first enabled clk already advances the
  // raster, and the strobe reads 0 whenever the block is idle.
  assign pix_en = en & ~rst & div_last_s;

endmodule

// File: rtl/vga_timing_gen_chk.sv
// vga_timing_gen_chk: elaboration-time legality checks on the timing
// parameters. No ports; instantiated inside vga_timing_gen.
module vga_timing_gen_chk #(
  parameter int CLK_DIV = 2,
  parameter int H_SYNC  = 96,
  parameter int H_BP    = 48,
  parameter int V_SYNC  = 2,
  parameter int V_BP    = 33
) ();

  if (CLK_DIV < 1) begin : g_bad_clk_div
    $error("vga_timing_gen: CLK_DIV must be at least 1");
  end
  // A back porch of at least one keeps the idle position outside the sync
  // and active windows and lets every decode threshold fit the counter width.
  if (H_BP < 1) begin : g_bad_h_bp
    $error("vga_timing_gen: H_BP must be at least 1");
  end
  if (V_BP < 1) begin : g_bad_v_bp
    $error("vga_timing_gen: V_BP must be at least 1");
  end
  if (H_SYNC < 1) begin : g_bad_h_sync
    $error("vga_timing_gen: H_SYNC must be at least 1");
  end
  if (V_SYNC < 1) begin : g_bad_v_sync
    $error("vga_timing_gen: V_SYNC must be at least 1");
  end

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA raster timing generator.
// Ports:
//   clk, rst        system clock, asynchronous active-high reset
//   en              run enable; low returns everything except frame_count to idle
//   pix_en          one-clk pixel strobe
//   column, row     raster position
//   display_active  position is inside the visible area
//   hsync, vsync    sync outputs at the configured polarity
//   line_start      one-clk pulse when column wraps to 0
//   frame_start     one-clk pulse when (row, column) wraps to (0,0)
//   frame_count     number of frame wraps, modulo 2^FRAME_W
// Idle sits on the last back-porch pixel so the first advance lands on (0,0)
// and is reported as a frame start.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int   CLK_DIV   = DEF_CLK_DIV,
  parameter int   H_ACTIVE  = DEF_H_ACTIVE,
  parameter int   H_FP      = DEF_H_FP,
  parameter int   H_SYNC    = DEF_H_SYNC,
  parameter int   H_BP      = DEF_H_BP,
  parameter int   V_ACTIVE  = DEF_V_ACTIVE,
  parameter int   V_FP      = DEF_V_FP,
  parameter int   V_SYNC    = DEF_V_SYNC,
  parameter int   V_BP      = DEF_V_BP,
  parameter logic HSYNC_POL = 1'b0,
  parameter logic VSYNC_POL = 1'b0,
  parameter int   FRAME_W   = DEF_FRAME_W
) (
  input  logic                                             clk,
  input  logic                                             rst,
  input  logic                                             en,
  output logic                                             pix_en,
  output logic [$clog2(H_ACTIVE+H_FP+H_SYNC+H_BP)-1:0]     column,
  output logic [$clog2(V_ACTIVE+V_FP+V_SYNC+V_BP)-1:0]     row,
  output logic                                             display_active,
  output logic                                             hsync,
  output logic                                             vsync,
  output logic                                             line_start,
  output logic                                             frame_start,
  output logic [FRAME_W-1:0]                               frame_count
);

  localparam vga_timing_t TIM = '{
    h_active: 16'(H_ACTIVE), h_fp: 16'(H_FP), h_sync: 16'(H_SYNC), h_bp: 16'(H_BP),
    v_active: 16'(V_ACTIVE), v_fp: 16'(V_FP), v_sync: 16'(V_SYNC), v_bp: 16'(V_BP)
  };
  localparam int H_TOTAL = int'(timing_total(TIM, AXIS_H));
  localparam int V_TOTAL = int'(timing_total(TIM, AXIS_V));
  localparam int CW      = $clog2(H_TOTAL);
  localparam int RW      = $clog2(V_TOTAL);

  // All thresholds are below H_TOTAL/V_TOTAL because the back porch is non-empty
  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT_C  = CW'(H_ACTIVE);
  localparam logic [CW-1:0] HS_BEG   = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_END   = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [RW-1:0] V_LAST   = RW'(V_TOTAL - 1);
  localparam logic [RW-1:0] V_ACT_C  = RW'(V_ACTIVE);
  localparam logic [RW-1:0] VS_BEG   = RW'(V_ACTIVE + V_FP);
  localparam logic [RW-1:0] VS_END   = RW'(V_ACTIVE + V_FP + V_SYNC);

  vga_timing_gen_chk #(
    .CLK_DIV (CLK_DIV),
    .H_SYNC  (H_SYNC),
    .H_BP    (H_BP),
    .V_SYNC  (V_SYNC),
    .V_BP    (V_BP)
  ) u_chk ();

  logic               pix_en_s;
  logic [CW-1:0]      col_nxt_s;
  logic [RW-1:0]      row_nxt_s;
  logic               line_wrap_s;
  logic               frame_wrap_s;
  logic               disp_nxt_s;
  logic               hs_nxt_s;
  logic               vs_nxt_s;

  logic [CW-1:0]      column_r;
  logic [RW-1:0]      row_r;
  logic               disp_r;
  logic               hs_r;
  logic               vs_r;
  logic               line_start_r;
  logic               frame_start_r;
  logic [FRAME_W-1:0] frame_count_r;

  pixel_clk_en #(
    .CLK_DIV (CLK_DIV)
  ) u_pix (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .pix_en (pix_en_s)
  );

  // Raster position advance on each pixel strobe, with line/frame wrap flags
  always_comb begin
    col_nxt_s    = column_r;
    row_nxt_s    = row_r;
    line_wrap_s  = 1'b0;
    frame_wrap_s = 1'b0;
    if (pix_en_s) begin
      if (column_r == H_LAST) begin
        col_nxt_s   = {CW{1'b0}};
        line_wrap_s = 1'b1;
        if (row_r == V_LAST) begin
          row_nxt_s    = {RW{1'b0}};
          frame_wrap_s = 1'b1;
        end else begin
          row_nxt_s = row_r + RW'(1);
        end
      end else begin
        col_nxt_s = column_r + CW'(1);
      end
    end else begin
      col_nxt_s = column_r;
      row_nxt_s = row_r;
    end
  end

  // Decode from the next position so outputs and counters update on the same edge
  always_comb begin
    disp_nxt_s = (col_nxt_s < H_ACT_C) && (row_nxt_s < V_ACT_C);
    if ((col_nxt_s >= HS_BEG) && (col_nxt_s < HS_END)) begin
      hs_nxt_s = HSYNC_POL;
    end else begin
      hs_nxt_s = ~HSYNC_POL;
    end
    if ((row_nxt_s >= VS_BEG) && (row_nxt_s < VS_END)) begin
      vs_nxt_s = VSYNC_POL;
    end else begin
      vs_nxt_s = ~VSYNC_POL;
    end
  end

  // Raster state: idle on reset or disable (frame_count only cleared by rst)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      column_r      <= H_LAST;
      row_r         <= V_LAST;
      disp_r        <= 1'b0;
      hs_r          <= ~HSYNC_POL;
      vs_r          <= ~VSYNC_POL;
      line_start_r  <= 1'b0;
      frame_start_r <= 1'b0;
      frame_count_r <= {FRAME_W{1'b0}};
    end else if (!en) begin
      column_r      <= H_LAST;
      row_r         <= V_LAST;
      disp_r        <= 1'b0;
      hs_r          <= ~HSYNC_POL;
      vs_r          <= ~VSYNC_POL;
      line_start_r  <= 1'b0;
      frame_start_r <= 1'b0;
      frame_count_r <= frame_count_r;
    end else begin
      column_r      <= col_nxt_s;
      row_r         <= row_nxt_s;
      disp_r        <= disp_nxt_s;
      hs_r          <= hs_nxt_s;
      vs_r          <= vs_nxt_s;
      line_start_r  <= line_wrap_s;
      frame_start_r <= frame_wrap_s;
      frame_count_r <= frame_wrap_s ? (frame_count_r + FRAME_W'(1)) : frame_count_r;
    end
  end

  assign pix_en         = pix_en_s;
  assign column         = column_r;
  assign row            = row_r;
  assign display_active = disp_r;
  assign hsync          = hs_r;
  assign vsync          = vs_r;
  assign line_start     = line_start_r;
  assign frame_start    = frame_start_r;
  assign frame_count    = frame_count_r;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three instances (default 640x480, a CLK_DIV=1 tiny
// raster with FRAME_W=2, and a CLK_DIV=3 tiny raster). A driver issues
// randomized en/rst stimulus and pushes the expected outputs, computed in
// closed form from elapsed enabled clks, into one queue per instance; a monitor
// on the falling edge pops and compares, and also checks strobe periods and
// the frame_count sequence on frame_start.
module tb_vga_timing_gen;

  typedef struct {
    int d, ha, hf, hs, hb, va, vf, vs, vb, fw;
    bit hp, vp;
  } cfg_t;

  typedef struct {
    bit pix, disp, hs, vs, ls, fs;
    int col, row, fc;
  } obs_t;

  logic clk = 1'b0;
  logic rst;
  logic en_a, en_b, en_c;

  always #5 clk = ~clk;

  logic       pix_a, disp_a, hs_a, vs_a, ls_a, fs_a;
  logic [9:0] col_a, row_a;
  logic [7:0] fc_a;
  logic       pix_b, disp_b, hs_b, vs_b, ls_b, fs_b;
  logic [2:0] col_b, row_b;
  logic [1:0] fc_b;
  logic       pix_c, disp_c, hs_c, vs_c, ls_c, fs_c;
  logic [2:0] col_c, row_c;
  logic [2:0] fc_c;

  vga_timing_gen u_a (
    .clk(clk), .rst(rst), .en(en_a), .pix_en(pix_a), .column(col_a), .row(row_a),
    .display_active(disp_a), .hsync(hs_a), .vsync(vs_a), .line_start(ls_a),
    .frame_start(fs_a), .frame_count(fc_a)
  );

  vga_timing_gen #(
    .CLK_DIV(1), .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
    .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b0), .FRAME_W(2)
  ) u_b (
    .clk(clk), .rst(rst), .en(en_b), .pix_en(pix_b), .column(col_b), .row(row_b),
    .display_active(disp_b), .hsync(hs_b), .vsync(vs_b), .line_start(ls_b),
    .frame_start(fs_b), .frame_count(fc_b)
  );

  vga_timing_gen #(
    .CLK_DIV(3), .H_ACTIVE(3), .H_FP(2), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(2), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b1), .FRAME_W(3)
  ) u_c (
    .clk(clk), .rst(rst), .en(en_c), .pix_en(pix_c), .column(col_c), .row(row_c),
    .display_active(disp_c), .hsync(hs_c), .vsync(vs_c), .line_start(ls_c),
    .frame_start(fs_c), .frame_count(fc_c)
  );

  int total = 0;
  int bad   = 0;

  obs_t   q_a[$], q_b[$], q_c[$];
  longint k_m[3];     // enabled clk edges since the instance was last idle
  longint base_m[3];  // frame_count held when the current run began

  function automatic cfg_t get_cfg(int i);
    cfg_t c;
    case (i)
      0:       c = '{d:2, ha:640, hf:16, hs:96, hb:48, va:480, vf:10, vs:2, vb:33, fw:8, hp:1'b0, vp:1'b0};
      1:       c = '{d:1, ha:4, hf:1, hs:1, hb:1, va:2, vf:1, vs:1, vb:1, fw:2, hp:1'b1, vp:1'b0};
      default: c = '{d:3, ha:3, hf:2, hs:2, hb:1, va:2, vf:1, vs:2, vb:1, fw:3, hp:1'b0, vp:1'b1};
    endcase
    return c;
  endfunction

  function automatic bit get_en(int i);
    case (i)
      0:       return en_a;
      1:       return en_b;
      default: return en_c;
    endcase
  endfunction

  // Reference: outputs after k enabled clk edges. Advances happen at every
  // D-th edge; advance n (n>=1) shows raster pixel n-1 of an endless stream.
  function automatic obs_t model(cfg_t c, longint k, longint base);
    obs_t   e;
    longint d, ht, vt, n, p, col, row, hsb, vsb;
    d   = longint'(c.d);
    ht  = longint'(c.ha + c.hf + c.hs + c.hb);
    vt  = longint'(c.va + c.vf + c.vs + c.vb);
    hsb = longint'(c.ha + c.hf);
    vsb = longint'(c.va + c.vf);
    n   = k / d;
    e.pix = (k >= 1) && ((k % d) == d - 1);
    if (n == 0) begin
      col  = ht - 1;
      row  = vt - 1;
      e.fc = int'(base);
    end else begin
      p    = n - 1;
      col  = p % ht;
      row  = (p / ht) % vt;
      e.fc = int'((base + p / (ht * vt) + 1) % (longint'(1) << c.fw));
    end
    e.col  = int'(col);
    e.row  = int'(row);
    e.disp = (col < longint'(c.ha)) && (row < longint'(c.va));
    e.hs   = (col >= hsb && col < hsb + longint'(c.hs)) ? c.hp : !c.hp;
    e.vs   = (row >= vsb && row < vsb + longint'(c.vs)) ? c.vp : !c.vp;
    e.ls   = (n >= 1) && ((k % d) == 0) && (col == 0);
    e.fs   = e.ls && (row == 0);
    return e;
  endfunction

  function automatic obs_t sample(int i);
    obs_t s;
    case (i)
      0: begin
        s.pix = pix_a; s.disp = disp_a; s.hs = hs_a; s.vs = vs_a; s.ls = ls_a; s.fs = fs_a;
        s.col = int'(col_a); s.row = int'(row_a); s.fc = int'(fc_a);
      end
      1: begin
        s.pix = pix_b; s.disp = disp_b; s.hs = hs_b; s.vs = vs_b; s.ls = ls_b; s.fs = fs_b;
        s.col = int'(col_b); s.row = int'(row_b); s.fc = int'(fc_b);
      end
      default: begin
        s.pix = pix_c; s.disp = disp_c; s.hs = hs_c; s.vs = vs_c; s.ls = ls_c; s.fs = fs_c;
        s.col = int'(col_c); s.row = int'(row_c); s.fc = int'(fc_c);
      end
    endcase
    return s;
  endfunction

  function automatic bit same(obs_t a, obs_t b);
    return a.pix == b.pix && a.disp == b.disp && a.hs == b.hs && a.vs == b.vs &&
           a.ls == b.ls && a.fs == b.fs && a.col == b.col && a.row == b.row && a.fc == b.fc;
  endfunction

  task automatic check(string nm, longint act, longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic check_obs(int i, longint cyc, obs_t s, obs_t e);
    total++;
    if (!same(s, e)) begin
      bad++;
      $display("FAIL raster dut%0d cyc=%0d: got pix=%0d col=%0d row=%0d da=%0d hs=%0d vs=%0d ls=%0d fs=%0d fc=%0d, expected pix=%0d col=%0d row=%0d da=%0d hs=%0d vs=%0d ls=%0d fs=%0d fc=%0d",
               i, cyc, s.pix, s.col, s.row, s.disp, s.hs, s.vs, s.ls, s.fs, s.fc,
               e.pix, e.col, e.row, e.disp, e.hs, e.vs, e.ls, e.fs, e.fc);
    end
  endtask

  // One clk: update each reference from the inputs seen at the edge, queue the
  // expectation, then return just after the falling edge.
  task automatic tick();
    obs_t cur;
    cfg_t c;
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      c = get_cfg(i);
      if (rst) begin
        k_m[i]    = 0;
        base_m[i] = 0;
      end else if (!get_en(i)) begin
        cur       = model(c, k_m[i], base_m[i]);
        base_m[i] = longint'(cur.fc);
        k_m[i]    = 0;
      end else begin
        k_m[i] = k_m[i] + 1;
      end
      cur = model(c, k_m[i], base_m[i]);
      case (i)
        0:       q_a.push_back(cur);
        1:       q_b.push_back(cur);
        default: q_c.push_back(cur);
      endcase
    end
    @(negedge clk);
    #1;
  endtask

  // Monitor: compare every clk, plus strobe periods and frame_count sequence
  longint cyc = 0;
  longint last_ls[3], last_fs[3];
  bit     have_ls[3], have_fs[3];
  int     seq_fc[3];

  always @(negedge clk) begin
    obs_t   e, s;
    cfg_t   c;
    longint lp;
    bit     got;
    cyc++;
    for (int i = 0; i < 3; i++) begin
      got = 1'b0;
      case (i)
        0:       if (q_a.size() > 0) begin e = q_a.pop_front(); got = 1'b1; end
        1:       if (q_b.size() > 0) begin e = q_b.pop_front(); got = 1'b1; end
        default: if (q_c.size() > 0) begin e = q_c.pop_front(); got = 1'b1; end
      endcase
      if (got) begin
        s = sample(i);
        c = get_cfg(i);
        check_obs(i, cyc, s, e);
        lp = longint'(c.d * (c.ha + c.hf + c.hs + c.hb));
        if (rst || !get_en(i)) begin
          have_ls[i] = 1'b0;
          have_fs[i] = 1'b0;
          if (rst) seq_fc[i] = 0;
        end else begin
          if (s.ls) begin
            if (have_ls[i]) check($sformatf("line_period dut%0d", i), cyc - last_ls[i], lp);
            last_ls[i] = cyc;
            have_ls[i] = 1'b1;
          end
          if (s.fs) begin
            if (have_fs[i]) check($sformatf("frame_period dut%0d", i), cyc - last_fs[i],
                                  lp * longint'(c.va + c.vf + c.vs + c.vb));
            last_fs[i] = cyc;
            have_fs[i] = 1'b1;
            seq_fc[i]  = (seq_fc[i] + 1) % (1 << c.fw);
            check($sformatf("fc_seq dut%0d", i), longint'(s.fc), longint'(seq_fc[i]));
          end
        end
      end
    end
  end

  initial begin
    rst  = 1'b1;
    en_a = 1'b1;
    en_b = 1'b1;
    en_c = 1'b1;
    for (int i = 0; i < 3; i++) begin
      k_m[i] = 0; base_m[i] = 0; have_ls[i] = 1'b0; have_fs[i] = 1'b0; seq_fc[i] = 0;
      last_ls[i] = 0; last_fs[i] = 0;
    end
    repeat (3) tick();

    // Reset state
    check("rst col_a", longint'(col_a), 799);
    check("rst row_a", longint'(row_a), 524);
    check("rst hs_a", longint'(hs_a), 1);
    check("rst vs_a", longint'(vs_a), 1);
    check("rst da_a", longint'(disp_a), 0);
    check("rst fc_a", longint'(fc_a), 0);
    check("rst pix_a", longint'(pix_a), 0);
    check("rst hs_b", longint'(hs_b), 0);
    check("rst pix_b", longint'(pix_b), 0);

    // Release: divide-by-2 strobe in clk 1, (0,0) at the end of clk 2
    rst = 1'b0;
    tick();
    check("clk1 pix_a", longint'(pix_a), 1);
    check("clk1 col_a", longint'(col_a), 799);
    check("clk1 fs_b", longint'(fs_b), 1);
    check("clk1 col_b", longint'(col_b), 0);
    tick();
    check("clk2 col_a", longint'(col_a), 0);
    check("clk2 row_a", longint'(row_a), 0);
    check("clk2 fs_a", longint'(fs_a), 1);
    check("clk2 ls_a", longint'(ls_a), 1);
    check("clk2 fc_a", longint'(fc_a), 1);
    tick();
    check("clk3 fs_a", longint'(fs_a), 0);
    check("clk3 ls_a", longint'(ls_a), 0);

    // Run to row 10, column 300 (pixel 8300 -> clk 2*8301), then disable
    repeat (16602 - 3) tick();
    check("pre-drop col_a", longint'(col_a), 300);
    check("pre-drop row_a", longint'(row_a), 10);
    en_a = 1'b0;
    tick();
    check("drop col_a", longint'(col_a), 799);
    check("drop row_a", longint'(row_a), 524);
    check("drop fc_a", longint'(fc_a), 1);
    check("drop pix_a", longint'(pix_a), 0);
    repeat (5) tick();
    en_a = 1'b1;
    tick();
    check("reen1 fs_a", longint'(fs_a), 0);
    tick();
    check("reen2 fs_a", longint'(fs_a), 1);
    check("reen2 fc_a", longint'(fc_a), 2);

    // Randomized enables with occasional resets
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 19) == 0) begin
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
      end else begin
        en_a = ($urandom_range(0, 3) != 0);
        en_b = ($urandom_range(0, 3) != 0);
        en_c = ($urandom_range(0, 3) != 0);
        repeat ($urandom_range(1, 500)) tick();
      end
    end
    en_a = 1'b1;
    en_b = 1'b1;
    en_c = 1'b1;
    repeat (200) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
